// File: rtl/ripple_count_checker.sv
// ripple_count_checker
//   Consumer of an asynchronous ripple-down counter. Brings the count into the
//   clk domain through a two-flop synchroniser, rejects ripple glitches with a
//   stability filter, and checks that each settled value is the previous one
//   minus one (mod 2^WIDTH). Reports lock/fault state, step/error pulses and a
//   saturating error count.
//
//   Build option: define STICKY_FAULT_EN to make FAULT terminal until reset or
//   enable is dropped. When it is undefined, a valid decrement seen in FAULT
//   returns the checker to TRACK.
module ripple_count_checker #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned ERR_W         = 8,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             enable,
    output logic [WIDTH-1:0] cur_val,
    output logic             step,
    output logic             err_pulse,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned       STAB_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ACC = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_TRACK,
        ST_FAULT
    } state_t;

    logic [WIDTH-1:0]  sync1_q, sync2_q;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic              accept;
    logic [WIDTH-1:0]  acc_val;
    logic [WIDTH-1:0]  dec_val;
    logic              is_same, is_dec;
    logic [ERR_W-1:0]  err_inc;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cur_val_q, cur_val_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              step_q, step_d;
    logic              err_pulse_q, err_pulse_d;

    // Two-flop synchroniser for the asynchronous ripple outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= cnt_in;
            sync2_q <= sync1_q;
        end
    end

    // Stability filter: restart on any change, count identical samples up to the limit.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            stab_d = STAB_W'(1);
        end else if (stab_q < STAB_MAX) begin
            stab_d = stab_q + STAB_W'(1);
        end
    end

    // Filter registers run regardless of FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q <= '0;
            stab_q <= '0;
        end else begin
            cand_q <= cand_d;
            stab_q <= stab_d;
        end
    end

    // Accept fires once per settled value; a value stable since before ACQUIRE
    // has already passed this point and needs a fresh change to be seen.
    assign accept  = (sync2_q == cand_q) && (stab_q == STAB_ACC);
    assign acc_val = cand_q;
    assign dec_val = cur_val_q - WIDTH'(1);
    assign is_same = (acc_val == cur_val_q);
    assign is_dec  = (acc_val == dec_val);
    assign err_inc = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_W'(1);

    // Next-state and registered-output logic for the sequence checker.
    always_comb begin
        state_d     = state_q;
        cur_val_d   = cur_val_q;
        err_cnt_d   = err_cnt_q;
        step_d      = 1'b0;
        err_pulse_d = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (accept) begin
                        cur_val_d = acc_val;
                        state_d   = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (accept && !is_same) begin
                        cur_val_d = acc_val;
                        if (is_dec) begin
                            step_d = 1'b1;
                        end else begin
                            err_pulse_d = 1'b1;
                            err_cnt_d   = err_inc;
                            state_d     = ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    if (accept && !is_same) begin
                        cur_val_d = acc_val;
`ifdef STICKY_FAULT_EN
                        if (!is_dec) begin
                            err_pulse_d = 1'b1;
                            err_cnt_d   = err_inc;
                        end
`else
                        if (is_dec) begin
                            step_d  = 1'b1;
                            state_d = ST_TRACK;
                        end else begin
                            err_pulse_d = 1'b1;
                            err_cnt_d   = err_inc;
                        end
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Checker state, tracked value, error count and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cur_val_q   <= '0;
            err_cnt_q   <= '0;
            step_q      <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_val_q   <= cur_val_d;
            err_cnt_q   <= err_cnt_d;
            step_q      <= step_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign cur_val   = cur_val_q;
    assign step      = step_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign locked    = (state_q == ST_TRACK);
    assign fault     = (state_q == ST_FAULT);

endmodule
